axi_rd_responder: RTL and testbench

//  AXI3-style read-channel slave that serves read bursts from a synchronous single-port word RAM.
//  It is the far end of the bursts issued by the fetch unit and the data port (arid/arlen/rid/rlast).
//  It is used as boot-ROM/scratch responder on the SoC side and as the memory model in CPU benches.
//  It queues up to FIFO_DEPTH outstanding AR requests and answers them strictly in order.

---
 rtl/axi_rd_responder_pkg.sv | 16 +
 rtl/axi_rd_responder_req_fifo.sv | 45 ++++
 rtl/axi_rd_responder.sv | 141 ++++++++++++++
 tb/tb_axi_rd_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_responder_pkg.sv
// rtl/axi_rd_responder_pkg.sv - shared AXI read-responder constants and FSM state type
package axi_rd_responder_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam int         AXI_ID_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } rd_state_t;

endpackage

// File: rtl/axi_rd_responder_req_fifo.sv
// rtl/axi_rd_responder_req_fifo.sv - synchronous AR request FIFO, pointers carry a wrap bit
module axi_rd_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] slots [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign head    = slots[rd_ptr[PW-1:0]];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) slots[wr_ptr[PW-1:0]] <= data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - in-order AXI3 read-burst slave over a synchronous word RAM
// Define AXI_RD_RSP_STALL_EN to insert LFSR-driven FETCH stalls (rvalid bubbles).
module axi_rd_responder
   import axi_rd_responder_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MEM_AW     = 12,
   parameter int ID_W       = AXI_ID_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ID_W-1:0]   arid,
   input  logic [31:0]       araddr,
   input  logic [3:0]        arlen,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata
);
   localparam int EW = ID_W + MEM_AW + 6;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rd_state_t         state, state_nx;
   logic [EW-1:0]     push_data, head;
   logic              full, empty, push, pop, stall;
   logic [CW-1:0]     fifo_count;
   logic [ID_W-1:0]   h_id;
   logic [MEM_AW-1:0] h_addr, cur_addr;
   logic [3:0]        h_len, beat_cnt;
   logic              h_fixed, h_err;
   logic              fresh, capture;
   logic [31:0]       rdata_q;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^araddr[31:MEM_AW+2];
   assign push_data = {arid, araddr[MEM_AW+1:2], arlen,
                       arburst == AXI_BURST_FIXED, araddr[1:0] != 2'b00};
   assign {h_id, h_addr, h_len, h_fixed, h_err} = head;

   assign arready = resetn && !full;
   assign push    = arvalid && arready;
   assign pop     = (state == ST_SEND) && rvalid && rready && rlast;

   axi_rd_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_req_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .data   (push_data),
      .pop    (pop),
      .head   (head),
      .full   (full),
      .empty  (empty),
      .count  (fifo_count)
   );

`ifdef AXI_RD_RSP_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk) begin
      if (!resetn) lfsr <= 16'hACE1;
      else         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // The head entry stays in the FIFO until its last beat; 'fresh' means cur_addr must come from it.
   assign mem_en   = (state == ST_FETCH);
   assign mem_addr = fresh ? h_addr : cur_addr;
   assign rdata    = capture ? (h_err ? 32'h0 : mem_rdata) : rdata_q;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (!empty) state_nx = ST_FETCH;
         ST_FETCH: if (!stall) state_nx = ST_SEND;
         ST_SEND: begin
            if (rready) begin
               if (!rlast || fifo_count != CW'(1) || push) state_nx = ST_FETCH;
               else                                        state_nx = ST_IDLE;
            end
         end
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         cur_addr <= '0;
         beat_cnt <= '0;
         fresh    <= 1'b0;
         capture  <= 1'b0;
         rdata_q  <= '0;
         rvalid   <= 1'b0;
         rid      <= '0;
         rresp    <= AXI_RESP_OKAY;
         rlast    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && !empty) begin
            fresh    <= 1'b1;
            beat_cnt <= '0;
         end
         if (state == ST_FETCH) begin
            fresh <= 1'b0;
            if (fresh) cur_addr <= h_addr;
            if (!stall) begin
               rvalid  <= 1'b1;
               capture <= 1'b1;
               rid     <= h_id;
               rresp   <= h_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               rlast   <= (beat_cnt == h_len);
            end
         end
         if (state == ST_SEND) begin
            capture <= 1'b0;
            if (capture) rdata_q <= h_err ? 32'h0 : mem_rdata;
            if (rready) begin
               rvalid <= 1'b0;
               if (!rlast) begin
                  beat_cnt <= beat_cnt + 4'd1;
                  cur_addr <= cur_addr + MEM_AW'(h_fixed ? 0 : 1);
               end else begin
                  fresh    <= 1'b1;
                  beat_cnt <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - directed self-checking bench for axi_rd_responder
module tb_axi_rd_responder;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [3:0]  arlen = '0;
   logic [1:0]  arburst = 2'b01;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        mem_en;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata = '0;

   int passed = 0;
   int total  = 0;

   axi_rd_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rid       (rid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM[w] = w; data is garbage unless a read was issued on the previous edge.
   always @(posedge clk) mem_rdata <= mem_en ? {20'h0, mem_addr} : 32'hDEAD_BEEF;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
      int w = 0;
      arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
      while (!arready && w < 50) begin
         step();
         w++;
      end
      total++;
      if (!arready) $display("FAIL ar_issue_timeout id=%0d arready=%b required 1", id, arready);
      else passed++;
      step();
      arvalid = 1'b0;
   endtask

   task automatic wait_rvalid(output int waited);
      waited = 0;
      while (!rvalid && waited < 40) begin
         step();
         waited++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      step();
      step();
      total++;
      if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rid !== 4'h0 ||
          rdata !== 32'h0 || rresp !== 2'b00 || mem_en !== 1'b0)
         $display("FAIL reset_state arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b mem_en=%b required all 0",
                  arready, rvalid, rlast, rid, rdata, rresp, mem_en);
      else passed++;
      resetn = 1'b1;
      step();
   endtask

   task automatic test_incr_burst();
      int w;
      rready = 1'b1;
      ar_issue(4'd0, 32'h40, 4'd15, 2'b01);
      wait_rvalid(w);
`ifndef AXI_RD_RSP_STALL_EN
      total++;
      if (w !== 2) $display("FAIL t1_first_latency cycles=%0d required 2", w);
      else passed++;
`endif
      for (int b = 0; b < 16; b++) begin
         if (b > 0) begin
            wait_rvalid(w);
`ifndef AXI_RD_RSP_STALL_EN
            total++;
            if (w !== 1) $display("FAIL t1_beat_gap beat=%0d gap=%0d required 1", b, w);
            else passed++;
`endif
         end
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h10 + b || rid !== 4'h0 || rresp !== 2'b00 ||
             rlast !== (b == 15))
            $display("FAIL t1_beat%0d rvalid=%b rdata=%h rid=%h rresp=%b rlast=%b required 1 %h 0 00 %b",
                     b, rvalid, rdata, rid, rresp, rlast, 32'h10 + b, b == 15);
         else passed++;
         step();
      end
   endtask

   task automatic test_fifo_full();
      int w;
      rready = 1'b0;
      for (int i = 1; i <= 4; i++) ar_issue(4'(i), 32'(4 * i), 4'd0, 2'b01);
      total++;
      if (arready !== 1'b0) $display("FAIL t2_full_arready arready=%b required 0", arready);
      else passed++;
      step(); step(); step();
      total++;
      if (arready !== 1'b0 || rvalid !== 1'b1 || rid !== 4'd1)
         $display("FAIL t2_stalled arready=%b rvalid=%b rid=%0d required 0 1 1", arready, rvalid, rid);
      else passed++;
      rready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_rvalid(w);
         total++;
         if (rvalid !== 1'b1 || rid !== 4'(b + 1) || rdata !== 32'(b + 1) || rlast !== 1'b1 ||
             rresp !== 2'b00)
            $display("FAIL t2_order%0d rvalid=%b rid=%0d rdata=%h rlast=%b rresp=%b required 1 %0d %h 1 00",
                     b, rvalid, rid, rdata, rlast, rresp, b + 1, 32'(b + 1));
         else passed++;
         step();
         if (b == 0) begin
            total++;
            if (arready !== 1'b1) $display("FAIL t2_arready_after_pop arready=%b required 1", arready);
            else passed++;
         end
      end
   endtask

   task automatic test_backpressure();
      int w;
      rready = 1'b1;
      ar_issue(4'd3, 32'h80, 4'd7, 2'b01);
      for (int b = 0; b < 8; b++) begin
         wait_rvalid(w);
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h20 + b || rid !== 4'd3 || rlast !== (b == 7))
            $display("FAIL t3_beat%0d rvalid=%b rdata=%h rid=%0d rlast=%b required 1 %h 3 %b",
                     b, rvalid, rdata, rid, rlast, 32'h20 + b, b == 7);
         else passed++;
         if (b == 2) begin
            rready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               step();
               total++;
               if (rvalid !== 1'b1 || rdata !== 32'h22 || rid !== 4'd3 || rlast !== 1'b0 ||
                   rresp !== 2'b00)
                  $display("FAIL t3_hold%0d rvalid=%b rdata=%h rid=%0d rlast=%b rresp=%b required 1 00000022 3 0 00",
                           h, rvalid, rdata, rid, rlast, rresp);
               else passed++;
            end
            rready = 1'b1;
         end
         step();
      end
   endtask

   task automatic test_slverr();
      int w;
      rready = 1'b1;
      ar_issue(4'd5, 32'h102, 4'd3, 2'b01);
      for (int b = 0; b < 4; b++) begin
         wait_rvalid(w);
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h0 || rid !== 4'd5 || rresp !== 2'b10 ||
             rlast !== (b == 3))
            $display("FAIL t4_err_beat%0d rvalid=%b rdata=%h rid=%0d rresp=%b rlast=%b required 1 0 5 10 %b",
                     b, rvalid, rdata, rid, rresp, rlast, b == 3);
         else passed++;
         step();
      end
      ar_issue(4'd6, 32'h20, 4'd0, 2'b01);
      wait_rvalid(w);
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'h8 || rid !== 4'd6 || rresp !== 2'b00 || rlast !== 1'b1)
         $display("FAIL t4_after_err rvalid=%b rdata=%h rid=%0d rresp=%b rlast=%b required 1 8 6 00 1",
                  rvalid, rdata, rid, rresp, rlast);
      else passed++;
      step();
   endtask

   task automatic test_fixed_and_wrap();
      int w;
      logic [31:0] exp_wrap [2];
      exp_wrap[0] = 32'hFFF;
      exp_wrap[1] = 32'h0;
      rready = 1'b1;
      ar_issue(4'd7, 32'h8, 4'd3, 2'b00);
      for (int b = 0; b < 4; b++) begin
         wait_rvalid(w);
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h2 || rid !== 4'd7 || rlast !== (b == 3))
            $display("FAIL t5_fixed%0d rvalid=%b rdata=%h rid=%0d rlast=%b required 1 2 7 %b",
                     b, rvalid, rdata, rid, rlast, b == 3);
         else passed++;
         step();
      end
      ar_issue(4'd8, 32'h3FFC, 4'd1, 2'b01);
      for (int b = 0; b < 2; b++) begin
         wait_rvalid(w);
         total++;
         if (rvalid !== 1'b1 || rdata !== exp_wrap[b] || rid !== 4'd8 || rlast !== (b == 1))
            $display("FAIL t5_wrap%0d rvalid=%b rdata=%h rid=%0d rlast=%b required 1 %h 8 %b",
                     b, rvalid, rdata, rid, rlast, exp_wrap[b], b == 1);
         else passed++;
         step();
      end
   endtask

   task automatic test_reset_mid_burst();
      int w;
      rready = 1'b1;
      ar_issue(4'd9, 32'h0, 4'd15, 2'b01);
      for (int b = 0; b < 3; b++) begin
         wait_rvalid(w);
         step();
      end
      wait_rvalid(w);
      resetn = 1'b0;
      step();
      total++;
      if (rvalid !== 1'b0 || arready !== 1'b0)
         $display("FAIL t6_in_reset rvalid=%b arready=%b required 0 0", rvalid, arready);
      else passed++;
      resetn = 1'b1;
      step();
      total++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || mem_en !== 1'b0)
         $display("FAIL t6_after_release rvalid=%b arready=%b mem_en=%b required 0 1 0",
                  rvalid, arready, mem_en);
      else passed++;
      step(); step(); step();
      total++;
      if (rvalid !== 1'b0 || mem_en !== 1'b0)
         $display("FAIL t6_no_residue rvalid=%b mem_en=%b required 0 0", rvalid, mem_en);
      else passed++;
      ar_issue(4'd10, 32'h40, 4'd1, 2'b01);
      for (int b = 0; b < 2; b++) begin
         wait_rvalid(w);
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h10 + b || rid !== 4'd10 || rlast !== (b == 1))
            $display("FAIL t6_new_burst%0d rvalid=%b rdata=%h rid=%0d rlast=%b required 1 %h 10 %b",
                     b, rvalid, rdata, rid, rlast, 32'h10 + b, b == 1);
         else passed++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_incr_burst();
      test_fifo_full();
      test_backpressure();
      test_slverr();
      test_fixed_and_wrap();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
